// File: rtl/freq_div_pkg.sv
// Shared types and constants for the freq_div_sched ratio scheduler.
package freq_div_pkg;

  localparam logic [3:0] N_MIN     = 4'd2;
  localparam logic [3:0] N_RST     = 4'd2;
  localparam int         REP_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_t;

  // rep is held at the widest supported REP_W; unused upper bits stay zero.
  typedef struct packed {
    logic [3:0]           n;
    logic [REP_W_MAX-1:0] rep;
  } sched_entry_t;

  localparam sched_entry_t ENTRY_RST = '{n: N_RST, rep: '0};

  function automatic logic [3:0] clamp_n(input logic [3:0] n);
    return (n < N_MIN) ? N_MIN : n;
  endfunction

endpackage

// File: rtl/freq_div_mirror.sv
// Cycle-exact copy of the frequency divider's phase counter: counts 1..N,
// flags the period end and the first cycle of each period.
module freq_div_mirror (
  input  logic       fin,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_n,
  output logic       o_wrap,
  output logic       o_period_start
);

  logic [3:0] r_count;

  assign o_wrap         = i_en && (r_count >= i_n);
  assign o_period_start = i_en && (r_count == 4'd1);

  // Held at 1 while disabled so the first enabled cycle matches the divider
  // leaving reset.
  always_ff @(posedge fin) begin
    // NOTE: non-blocking updates keep every flop reading pre-edge values;
    // a blocking write here would race against other readers of r_count.
    if (rst) begin
      r_count <= 4'd1;
    end else if (!i_en || (r_count >= i_n)) begin
      r_count <= 4'd1;
    end else begin
      r_count <= r_count + 4'd1;
    end
  end

endmodule

// File: rtl/freq_div_sched.sv
// Ratio scheduler driving a frequency divider's N and rst_n from a (N, repeat)
// table. Define FREQ_DIV_SCHED_LOOP_EN to repeat the schedule until stopped.
module freq_div_sched
  import freq_div_pkg::*;
#(
  parameter int DEPTH = 4,  // power of two, 2..16
  parameter int REP_W = 8   // up to REP_W_MAX
) (
  input  logic                     fin,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [3:0]               cfg_n,
  input  logic [REP_W-1:0]         cfg_rep,
  input  logic                     start,
  input  logic                     stop,
  output logic [3:0]               div_n,
  output logic                     div_rst_n,
  output logic                     period_start,
  output logic                     busy,
  output logic                     done
);

  localparam int IDX_W = $clog2(DEPTH);

  sched_state_t     r_state;
  sched_entry_t     r_tbl [DEPTH];
  logic [IDX_W-1:0] r_idx;
  logic [REP_W-1:0] r_rep_left;
  logic [3:0]       r_div_n;
  logic             r_div_rst_n;
  logic             r_done;

  logic             w_active;
  logic             w_cfg_fire;
  logic             w_wrap;
  logic             w_period_start;
  logic             w_idx_last;
  logic             w_sched_end;
  logic [IDX_W-1:0] w_next_idx;
  sched_entry_t     w_cfg_entry;
  sched_entry_t     w_tbl0;
  sched_entry_t     w_next_entry;

  assign w_active    = (r_state != IDLE);
  assign cfg_ready   = (r_state == IDLE);
  assign w_cfg_fire  = cfg_valid && cfg_ready;
  assign w_cfg_entry = '{n: clamp_n(cfg_n), rep: REP_W_MAX'(cfg_rep)};

  // Entry 0 as it will be after this edge, so a start coinciding with a
  // write to entry 0 runs the new data.
  assign w_tbl0 = (w_cfg_fire && (cfg_idx == '0)) ? w_cfg_entry : r_tbl[0];

  assign w_next_idx   = r_idx + IDX_W'(1);
  assign w_idx_last   = (r_idx == IDX_W'(DEPTH - 1));
  assign w_next_entry = r_tbl[w_next_idx];
  assign w_sched_end  = w_idx_last || (w_next_entry.rep == '0);

  freq_div_mirror u_mirror (
    .fin            (fin),
    .rst            (rst),
    .i_en           (w_active),
    .i_n            (r_div_n),
    .o_wrap         (w_wrap),
    .o_period_start (w_period_start)
  );

  always_ff @(posedge fin) begin
    // NOTE: the table is reset explicitly; rep=0 is the end-of-schedule
    // marker, so stale contents after reset would start a bogus schedule.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= ENTRY_RST;
    end else if (w_cfg_fire) begin
      r_tbl[cfg_idx] <= w_cfg_entry;
    end
  end

  always_ff @(posedge fin) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_rep_left  <= '0;
      r_div_n     <= N_RST;
      r_div_rst_n <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (w_tbl0.rep != '0) begin
              r_state     <= RUN;
              r_idx       <= '0;
              r_div_n     <= w_tbl0.n;
              r_rep_left  <= w_tbl0.rep[REP_W-1:0];
              r_div_rst_n <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_wrap) begin
            if (stop) begin
              r_state     <= IDLE;
              r_div_rst_n <= 1'b0;
            end else if (r_rep_left > REP_W'(1)) begin
              r_rep_left <= r_rep_left - REP_W'(1);
            end else if (!w_sched_end) begin
              r_idx      <= w_next_idx;
              r_div_n    <= w_next_entry.n;
              r_rep_left <= w_next_entry.rep[REP_W-1:0];
`ifdef FREQ_DIV_SCHED_LOOP_EN
            end else if (r_tbl[0].rep != '0) begin
              r_idx      <= '0;
              r_div_n    <= r_tbl[0].n;
              r_rep_left <= r_tbl[0].rep[REP_W-1:0];
`endif
            end else begin
              r_state     <= IDLE;
              r_div_rst_n <= 1'b0;
              r_done      <= 1'b1;
            end
          end else if (stop) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_wrap) begin
            r_state     <= IDLE;
            r_div_rst_n <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_div_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign div_n        = r_div_n;
  assign div_rst_n    = r_div_rst_n;
  assign period_start = w_period_start;
  assign busy         = w_active;
  assign done         = r_done;

endmodule

// File: tb/tb_freq_div_sched.sv
// Scoreboard bench for freq_div_sched: a table-level model predicts the
// sequence of output periods and done pulses; a monitor measures the DUT.
module tb_freq_div_sched;

  localparam int DEPTH = 4;
  localparam int REP_W = 8;
  localparam int IDX_W = 2;
`ifdef FREQ_DIV_SCHED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic             fin       = 1'b0;
  logic             rst       = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [IDX_W-1:0] cfg_idx   = '0;
  logic [3:0]       cfg_n     = '0;
  logic [REP_W-1:0] cfg_rep   = '0;
  logic             start     = 1'b0;
  logic             stop      = 1'b0;
  logic             cfg_ready;
  logic [3:0]       div_n;
  logic             div_rst_n;
  logic             period_start;
  logic             busy;
  logic             done;

  freq_div_sched #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .fin          (fin),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_idx      (cfg_idx),
    .cfg_n        (cfg_n),
    .cfg_rep      (cfg_rep),
    .start        (start),
    .stop         (stop),
    .div_n        (div_n),
    .div_rst_n    (div_rst_n),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  always #5 fin = ~fin;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_done;
    int n;
  } ev_t;

  ev_t exp_q[$];
  int  m_n   [DEPTH];
  int  m_rep [DEPTH];

  bit in_period = 1'b0;
  int cur_n     = 0;
  int cur_len   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", name, got, exp, $time);
    end
  endtask

  task automatic close_period();
    ev_t e;
    in_period = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_period got n=%0d len=%0d exp=none @%0t", cur_n, cur_len, $time);
    end else begin
      e = exp_q.pop_front();
      check("period_kind", 32'(e.is_done), 32'd0);
      check("period_n", cur_n, e.n);
      check("period_len", cur_len, e.n);
    end
  endtask

  task automatic take_done();
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done got=1 exp=0 @%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("done_kind", 32'(e.is_done), 32'd1);
      check("done_busy_low", 32'(busy), 32'd0);
    end
  endtask

  // Monitor: measures each period between period_start pulses / busy fall.
  always @(negedge fin) begin
    if (rst) begin
      in_period = 1'b0;
    end else begin
      check("rst_n_vs_busy", 32'(div_rst_n), 32'(busy));
      check("ready_vs_busy", 32'(cfg_ready), 32'(!busy));
      if (in_period && (period_start || !busy)) close_period();
      if (period_start) begin
        in_period = 1'b1;
        cur_n     = int'(div_n);
        cur_len   = 1;
      end else if (in_period) begin
        cur_len++;
        check("div_n_stable", 32'(div_n), cur_n);
      end
      if (done) take_done();
    end
  end

  task automatic step();
    @(posedge fin);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_n[i]   = 2;
      m_rep[i] = 0;
    end
  endtask

  task automatic wr(input int idx, input int n, input int rep);
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_idx   = IDX_W'(idx);
    cfg_n     = 4'(n);
    cfg_rep   = REP_W'(rep);
    step();
    cfg_valid  = 1'b0;
    m_n[idx]   = (n < 2) ? 2 : n;
    m_rep[idx] = rep;
  endtask

  function automatic int pass_len();
    int t = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_rep[i] == 0) break;
      t += m_n[i] * m_rep[i];
    end
    return t;
  endfunction

  // Reference: walk the table entry by entry; a stop inside a period lets
  // that period finish and nothing follows it.
  task automatic expect_run(input int stop_at);
    int cyc = 0;
    int idx = 0;
    if (m_rep[0] == 0) begin
      exp_q.push_back('{1'b1, 0});
      return;
    end
    for (int guard = 0; guard < 5000; guard++) begin
      for (int r = 0; r < m_rep[idx]; r++) begin
        exp_q.push_back('{1'b0, m_n[idx]});
        cyc += m_n[idx];
        if (stop_at != 0 && cyc >= stop_at) return;
      end
      idx++;
      if (idx == DEPTH || m_rep[idx] == 0) begin
        if (!LOOP) begin
          exp_q.push_back('{1'b1, 0});
          return;
        end
        idx = 0;
      end
    end
  endtask

  task automatic run(input int stop_at_in, input bit junk, input bit ws,
                     input int ws_n, input int ws_rep, input int exp_done_cyc);
    int stop_at  = stop_at_in;
    int done_cyc = 0;
    bit finished = 1'b0;
    if (ws) begin
      check("cfg_ready_ws", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_idx   = '0;
      cfg_n     = 4'(ws_n);
      cfg_rep   = REP_W'(ws_rep);
      m_n[0]    = (ws_n < 2) ? 2 : ws_n;
      m_rep[0]  = ws_rep;
    end
    if (LOOP && stop_at == 0) stop_at = pass_len();
    expect_run(stop_at);
    start = 1'b1;
    step();
    start     = 1'b0;
    cfg_valid = 1'b0;
    if (m_rep[0] != 0) begin
      check("first_period_start", 32'(period_start), 32'd1);
      check("first_busy", 32'(busy), 32'd1);
      check("first_div_n", 32'(div_n), m_n[0]);
    end
    for (int c = 1; c < 4000; c++) begin
      if (done) done_cyc = c;
      if (c > stop_at && !busy && !in_period && exp_q.size() == 0) begin
        finished = 1'b1;
        break;
      end
      if (junk && c == 1 && busy) begin
        cfg_valid = 1'b1;
        cfg_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
        cfg_n     = 4'($urandom_range(0, 15));
        cfg_rep   = REP_W'($urandom_range(0, 3));
        check("cfg_ready_run", 32'(cfg_ready), 32'd0);
      end
      if (c == stop_at) stop = 1'b1;
      step();
      stop      = 1'b0;
      cfg_valid = 1'b0;
    end
    check("run_complete", 32'(finished), 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    if (exp_done_cyc != 0) check("done_cycle", done_cyc, exp_done_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stop_at;

    do_reset();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_div_n", 32'(div_n), 32'd2);
    check("rst_div_rst_n", 32'(div_rst_n), 32'd0);
    check("rst_period_start", 32'(period_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Two entries then end marker: 4,4,6 then done at cycle 15.
    wr(0, 4, 2);
    wr(1, 6, 1);
    run(0, 1'b1, 1'b0, 0, 0, LOOP ? 0 : 15);

    // N below the minimum is stored as 2.
    wr(0, 1, 1);
    wr(1, 9, 0);
    run(0, 1'b0, 1'b0, 0, 0, LOOP ? 0 : 3);

    // Stop mid-period: the 8-cycle period completes, no done.
    wr(0, 8, 3);
    run(5, 1'b0, 1'b0, 0, 0, 0);

    // Stop exactly on a period-end cycle.
    wr(0, 3, 4);
    run(6, 1'b0, 1'b0, 0, 0, 0);

    // Write and start on the same edge.
    run(0, 1'b0, 1'b1, 10, 1, LOOP ? 0 : 11);

    // Reset mid-run clears the table.
    wr(0, 15, 200);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    do_reset();
    check("midrst_div_n", 32'(div_n), 32'd2);
    check("midrst_div_rst_n", 32'(div_rst_n), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    run(0, 1'b0, 1'b0, 0, 0, 1);

    // Alternating ratios; loops in the loop build until stopped.
    wr(0, 3, 1);
    wr(1, 5, 1);
    run(LOOP ? 20 : 0, 1'b0, 1'b0, 0, 0, LOOP ? 0 : 9);

    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(0, 1) == 1) wr(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
      if (LOOP || $urandom_range(0, 1) == 1) stop_at = int'($urandom_range(1, 2 * pass_len() + 1));
      else stop_at = 0;
      run(stop_at, it[0], 1'b0, 0, 0, 0);
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
